// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer: steps a DDS tuning word from start towards stop, holding each word dwell+1 clocks.
// Optional triangle (up/down) sweep when DDS_SWEEP_TRI_EN is defined; sawtooth otherwise.
module dds_sweep_ctrl #(
  parameter int FW_W    = 64,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [FW_W-1:0]    f_start,
  input  logic [FW_W-1:0]    f_stop,
  input  logic [FW_W-1:0]    f_step,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               loop,
  output logic [FW_W-1:0]    freq_word,
  output logic               freq_upd,
  output logic               busy,
  output logic               done,
  output logic               dbg_state
);

  typedef enum logic {S_IDLE = 1'b0, S_DWELL = 1'b1} state_t;

  state_t             state_q;
  logic [FW_W-1:0]    word_q;
  logic [FW_W-1:0]    start_q;
  logic [FW_W-1:0]    stop_q;
  logic [FW_W-1:0]    step_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] cnt_q;
  logic               loop_q;
  logic               upd_q;
  logic               busy_q;
  logic               done_q;

  // The extra MSB of the sum is the carry; a carry counts as overshooting stop.
  logic [FW_W:0] up_sum;
  logic          up_ok;

  assign up_sum = {1'b0, word_q} + {1'b0, step_q};
  assign up_ok  = ~up_sum[FW_W] && (up_sum[FW_W-1:0] <= stop_q);

`ifdef DDS_SWEEP_TRI_EN
  logic          dir_q;
  logic [FW_W:0] dn_diff;
  logic          dn_ok;

  assign dn_diff = {1'b0, word_q} - {1'b0, step_q};
  assign dn_ok   = ~dn_diff[FW_W] && (dn_diff[FW_W-1:0] >= start_q);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      start_q <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
      loop_q  <= 1'b0;
      upd_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DDS_SWEEP_TRI_EN
      dir_q   <= 1'b0;
`endif
    end else begin
      upd_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            start_q <= f_start;
            stop_q  <= f_stop;
            step_q  <= f_step;
            dwell_q <= dwell;
            loop_q  <= loop;
            word_q  <= f_start;
            cnt_q   <= dwell;
            upd_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_DWELL;
`ifdef DDS_SWEEP_TRI_EN
            dir_q   <= 1'b0;
`endif
          end
        end
        S_DWELL: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - DWELL_W'(1);
          end else begin
            cnt_q <= dwell_q;
`ifdef DDS_SWEEP_TRI_EN
            // Up overshoot falls through to a down step; a failing down step is the underflow rule.
            if (!dir_q && up_ok) begin
              word_q <= up_sum[FW_W-1:0];
              upd_q  <= (step_q != '0);
            end else if (dn_ok) begin
              dir_q  <= 1'b1;
              word_q <= dn_diff[FW_W-1:0];
              upd_q  <= 1'b1;
            end else if (loop_q) begin
              dir_q  <= 1'b0;
              word_q <= up_sum[FW_W-1:0];
              upd_q  <= 1'b1;
            end else begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
`else
            // A zero step re-arms the dwell without announcing a new word.
            if (up_ok) begin
              word_q <= up_sum[FW_W-1:0];
              upd_q  <= (step_q != '0);
            end else if (loop_q) begin
              word_q <= start_q;
              upd_q  <= 1'b1;
            end else begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
`endif
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign freq_word = word_q;
  assign freq_upd  = upd_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = (state_q == S_DWELL);

endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Frequency-sweep sequencer for the DDS phase accumulator. It holds a 64-bit tuning word and steps it from a start word towards a stop word by a fixed increment, holding each word for a programmable number of clocks. Its `freq_word` output drives the accumulator increment input directly, replacing the fixed `Freq` parameter, so the 12-bit sine ROM output becomes a chirp/sweep carrier.

## Interface
- `FW_W`, 64: tuning-word width; equals the accumulator width.
- `DWELL_W`, 16: dwell-counter width.

- `clk` in 1: sampling clock, same clock as the accumulator.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: one-cycle request; accepted only in IDLE.
- `abort` in 1: stop the sweep; acts only in DWELL.
- `f_start` in FW_W: first tuning word.
- `f_stop` in FW_W: last allowed tuning word (inclusive, unsigned).
- `f_step` in FW_W: increment per step (unsigned).
- `dwell` in DWELL_W: each word is held for `dwell+1` clocks.
- `loop` in 1: 1 = restart at `f_start` after the end instead of finishing.
- `freq_word` out FW_W: current tuning word to the accumulator.
- `freq_upd` out 1: pulses in the same cycle `freq_word` takes a new value.
- `busy` out 1: high while in DWELL.
- `done` out 1: one-cycle pulse on normal sweep completion.

## Operation
- States: IDLE, DWELL.
- **IDLE, `start`=1:**
  - Latch `f_start`, `f_stop`, `f_step`, `dwell` and `loop` into shadow registers. Later input changes have no effect until the next start.
  - Set `freq_word`←`f_start`, pulse `freq_upd`, load the dwell counter with `dwell`, and go to DWELL.
- **DWELL, each cycle:**
  - If `abort`=1: go to IDLE. `freq_word` holds its value, with no `done` and no `freq_upd`.
  - Otherwise, if the counter ≠ 0: decrement it.
  - Otherwise compute `next = freq_word + step` in FW_W+1 bits:
    - If there is no carry and `next ≤ stop`: `freq_word`←`next`, pulse `freq_upd`, reload the counter.
    - Else, if `loop`=1: `freq_word`←shadow `start`, pulse `freq_upd`, reload the counter.
    - Else: pulse `done` and go to IDLE. `freq_word` keeps the last in-range word.
- `start` while busy is ignored. `start` and `abort` together in IDLE: `start` is accepted.
- `f_step`=0: the word never advances. The block stays in DWELL until `abort`, re-arming the counter each period without `freq_upd`.
- `f_start` > `f_stop`: `f_start` is output for one dwell period, then the end condition applies (finish, or reload if looping).
- All compares are unsigned. Wrap-around of the word is impossible because the carry is treated as overshoot.

## Timing
- Reset values: `freq_word`=0, `freq_upd`=0, `busy`=0, `done`=0, state IDLE, counter 0, shadows 0.
- A reset mid-sweep returns everything to reset values immediately.
- Latency from `start` to output: `start` is sampled at edge N. After edge N, `freq_word`=`f_start`, `freq_upd`=1 and `busy`=1.
- Step timing: a word entered after edge M is replaced after edge M+`dwell`+1.
- End of sweep: `done`=1 and `busy`=0 appear after the same edge. `done` lasts exactly one cycle.
- Abort: `abort` sampled at edge K gives `busy`=0 after edge K. A new `start` is accepted at edge K+1.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- Macro `DDS_SWEEP_TRI_EN`:
  - Defined: triangle sweep, with a direction register (reset and start value = up).
    - Up overshoot: set dir=down and `freq_word`←`freq_word`−step.
    - Down step: `next = freq_word − step`. A borrow or `next < start` is an underflow.
    - Underflow with `loop`=0: `done`. Underflow with `loop`=1: set dir=up and `freq_word`←`freq_word`+step.
    - If the first down step itself underflows, apply the underflow rule immediately.
  - Undefined: sawtooth behaviour exactly as in Operation; no direction logic is synthesized.

## Test plan
- Basic sweep: `f_start`=100, `f_stop`=130, `f_step`=10, `dwell`=2, `loop`=0 → words 100, 110, 120, 130, each held 3 cycles with `freq_upd` at each change. `done` pulses 12 cycles after the start edge. `freq_word` stays 130.
- Loop: same setup with `loop`=1 → the word sequence 100, 110, 120, 130 repeats, with no `done`. Assert `abort` mid-period → `busy`=0 next cycle and the word is held.
- Overflow: `f_start`=2^64−20, `f_step`=16, `f_stop`=2^64−1, `dwell`=0 → words 2^64−20, 2^64−4. `done` follows on the next cycle (carry treated as overshoot).
- Edge cases:
  - `f_step`=0 → no `freq_upd` after the first word until `abort`.
  - `f_start`=50, `f_stop`=40 → word 50 for one dwell period, then `done`.
  - `start` while busy → ignored.
- Reset: assert `rst_n` low mid-sweep → all outputs 0 at once. A `start` after release restarts cleanly from `f_start`.
- With `DDS_SWEEP_TRI_EN`: 100/130/10, `dwell`=0, `loop`=0 → words 100, 110, 120, 130, 120, 110, 100, then `done`.
